krnl_idct_mul_pipe: RTL and testbench
=====================================

# krnl_idct_mul_pipe

Parametrised, fully pipelined signed multiplier for the IDCT kernel datapath, the successor to the fixed 16×16→16 four-stage DSP multiplier. Adds configurable operand and result widths and pipeline depth, valid tracking, an optional multiply-accumulate mode with frame markers, rounding right-shift, and saturation with an overflow flag. Sits between the coefficient/sample fetch stage and the IDCT butterfly adders, accepting one operand pair per enabled cycle.

## Interface
- DIN0_WIDTH, 16: signed width of din0.
- DIN1_WIDTH, 16: signed width of din1.
- DOUT_WIDTH, 16: signed width of dout; must be ≤ DIN0_WIDTH+DIN1_WIDTH+ACC_GUARD.
- NUM_STAGE, 4: base latency in enabled cycles; legal range 3..8.
- ACC_EN, 0: 1 inserts the accumulator stage.
- ACC_GUARD, 4: accumulator guard bits above the product width.
- SHIFT, 0: arithmetic right shift applied before output; legal range 0..P-1, where P = DIN0_WIDTH+DIN1_WIDTH.
- ROUND, 0: 0 truncate (floor); 1 round half up (add 2^(SHIFT-1) before the shift; no effect when SHIFT=0).
- SAT, 0: 0 wrap to DOUT_WIDTH; 1 clamp to the signed DOUT range.
- clk, in, 1: single clock, rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- ce, in, 1: global clock enable; 0 freezes every register.
- in_valid, in, 1: operand pair is valid.
- din0, in, DIN0_WIDTH: signed operand.
- din1, in, DIN1_WIDTH: signed operand.
- acc_first, in, 1: ACC_EN=1 only; this sample starts a new sum.
- acc_last, in, 1: ACC_EN=1 only; this sample closes the sum.
- out_valid, out, 1: dout/ovf valid.
- dout, out, DOUT_WIDTH: signed result.
- ovf, out, 1: the pre-wrap or pre-clamp value exceeded the DOUT range.

## Operation
- Pipeline stages:
  - S1: register operands, valid and markers.
  - S2: full-precision product, P bits, never truncated.
  - S3..S(NUM_STAGE-1): delay registers.
  - Final stage: shift, round and saturate, then register.
- ACC_EN=1 adds stage SA after S2. SA holds the accumulator, ACC_WIDTH = P+ACC_GUARD bits:
  - valid sample with acc_first=1: acc ← sign-extended product.
  - valid sample with acc_first=0: acc ← acc + product, wrapping in ACC_WIDTH.
  - acc_first and acc_last both 1: a one-term sum.
  - Only a sample with acc_last=1 propagates valid past SA. Intermediate samples produce no output.
- Output formatting on value v (the product, or acc):
  - r = (v + (ROUND && SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, computed at one bit wider than v so the rounding add cannot overflow.
  - ovf = r outside [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1].
  - SAT=1: dout is clamped to that range.
  - SAT=0: dout = r[DOUT_WIDTH-1:0].
- in_valid=0 samples flow through as bubbles. Data registers may load, but valid stays 0 and the accumulator does not change.
- acc_first and acc_last are ignored when in_valid=0, and ignored entirely when ACC_EN=0.

## Timing
- Latency: NUM_STAGE enabled cycles from the input sample to out_valid; NUM_STAGE+1 when ACC_EN=1, measured from the acc_last sample.
- Throughput: one sample per enabled cycle. There is no backpressure.
- ce=0: all state, including out_valid/dout/ovf, holds its value. A held out_valid=1 is one result presented for multiple cycles; the consumer qualifies it with ce.
- Reset (asynchronous assert, synchronous release): all valid bits, acc, dout and ovf are 0. A reset mid-stream discards in-flight samples and any partial sum.
- After reset, a sample with acc_first=0 accumulates onto 0.
- Outputs are registered only; there is no combinational path from any input to any output.

## Structure
- Package krnl_idct_mul_pkg:
  - ROUND_TRUNC=0 and ROUND_HALF_UP=1 constants.
  - Functions smax(w) and smin(w) returning the signed range limits.
  - ACC_WIDTH derivation function.
- Sub-module krnl_idct_round_sat: parametrised by input width, SHIFT, ROUND, SAT and DOUT_WIDTH; combinational shift/round/clamp/ovf. The top level registers its output.
- Top level holds the valid/marker shift registers, the product stage and the optional accumulator.

## Test plan
- Defaults, SAT=0: din0=300, din1=200 → after 4 cycles, out_valid=1, dout=0xEA60 (−5536), ovf=1. With SAT=1: dout=32767, ovf=1.
- SHIFT=2, din0=−7, din1=3 (−21):
  - ROUND=1 → dout=−5, ovf=0.
  - ROUND=0 → dout=−6.
  - Also check −2^15 × −2^15 with SAT=1 → 32767, ovf=1.
- Back-to-back inputs 1..20 × 2 with ce=1 throughout → outputs 2..40 on 20 consecutive cycles starting at cycle 4. Then drop ce for 3 cycles mid-stream → outputs stall and hold, with no loss or duplication.
- ACC_EN=1, SAT=1, four samples of 1000×10, acc_first on the first sample and acc_last on the fourth:
  - single out_valid pulse at NUM_STAGE+1 after the last sample, dout=32767, ovf=1.
  - repeat with 100×10 → dout=4000.
  - interleaved in_valid=0 bubbles do not change the sum.
- Assert reset_n low asynchronously (mid-cycle) with 3 samples in flight and a partial sum → out_valid, dout, ovf and acc all 0 immediately. After release, the next sample with acc_first=0 yields its bare product.
- Sweep NUM_STAGE=3 and 8 at DIN0_WIDTH=12, DIN1_WIDTH=18, DOUT_WIDTH=24 with random operands → a bit-exact match against the reference-model formula at exactly NUM_STAGE latency.

Source files
------------

// File: rtl/krnl_idct_mul_pkg.sv
// Shared constants and helpers for the IDCT kernel multiplier and its
// output formatter.
package krnl_idct_mul_pkg;

    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_HALF_UP = 1;

    // Accumulator width: full product plus guard bits against wrap in a sum.
    function automatic int acc_width(input int prod_width, input int guard);
        return prod_width + guard;
    endfunction

    function automatic longint smax(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint smin(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/krnl_idct_round_sat.sv
// Combinational output formatter: arithmetic right shift with optional
// round-half-up, then wrap or clamp to the signed output range with overflow flag.
module krnl_idct_round_sat
    import krnl_idct_mul_pkg::*;
#(
    parameter int IN_WIDTH   = 32,
    parameter int SHIFT      = 0,
    parameter int ROUND      = ROUND_TRUNC,
    parameter int SAT        = 0,
    parameter int DOUT_WIDTH = 16
) (
    input  logic signed [IN_WIDTH-1:0]   val_i,
    output logic signed [DOUT_WIDTH-1:0] dout_o,
    output logic                         ovf_o
);

    // One extra bit so adding the rounding constant can never overflow.
    localparam int RW     = IN_WIDTH + 1;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [RW-1:0] RND =
        (ROUND == ROUND_HALF_UP && SHIFT > 0) ? (RW'(1) << RND_SH) : '0;

    logic signed [RW-1:0] sum;
    logic signed [RW-1:0] r;

    assign sum = $signed(RW'(val_i)) + $signed(RND);
    assign r   = sum >>> SHIFT;

    generate
        if (DOUT_WIDTH >= RW) begin : g_fits
            assign dout_o = DOUT_WIDTH'(r);
            assign ovf_o  = 1'b0;
        end else begin : g_narrow
            // r fits when every bit from the output sign bit upward agrees.
            logic [RW-DOUT_WIDTH:0] top;
            logic                   fits;

            assign top  = r[RW-1:DOUT_WIDTH-1];
            assign fits = (&top) | ~(|top);

            // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
            always_comb begin
                ovf_o  = ~fits;
                dout_o = r[DOUT_WIDTH-1:0];
                if (SAT != 0 && !fits) begin
                    dout_o = r[RW-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                                     : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/krnl_idct_mul_pipe.sv
// Pipelined signed multiplier for the IDCT datapath with optional
// multiply-accumulate, rounding shift and saturation on a registered output.
module krnl_idct_mul_pipe
    import krnl_idct_mul_pkg::*;
#(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 16,
    parameter int DOUT_WIDTH = 16,
    parameter int NUM_STAGE  = 4,
    parameter int ACC_EN     = 0,
    parameter int ACC_GUARD  = 4,
    parameter int SHIFT      = 0,
    parameter int ROUND      = ROUND_TRUNC,
    parameter int SAT        = 0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         ce,
    input  logic                         in_valid,
    input  logic signed [DIN0_WIDTH-1:0] din0,
    input  logic signed [DIN1_WIDTH-1:0] din1,
    input  logic                         acc_first,
    input  logic                         acc_last,
    output logic                         out_valid,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         ovf
);

    localparam int P     = DIN0_WIDTH + DIN1_WIDTH;
    localparam int ACC_W = acc_width(P, ACC_GUARD);
    localparam int VW    = (ACC_EN != 0) ? ACC_W : P;
    localparam int ND    = NUM_STAGE - 3;

    // S1: operands and qualified markers
    logic signed [DIN0_WIDTH-1:0] a_q;
    logic signed [DIN1_WIDTH-1:0] b_q;
    logic                         v1_q, f1_q, l1_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q  <= '0;
            b_q  <= '0;
            v1_q <= 1'b0;
            f1_q <= 1'b0;
            l1_q <= 1'b0;
        end else if (ce) begin
            a_q  <= din0;
            b_q  <= din1;
            v1_q <= in_valid;
            f1_q <= in_valid & acc_first;
            l1_q <= in_valid & acc_last;
        end
    end

    // S2: full-precision product
    logic signed [P-1:0] a_ext, b_ext, prod_d, prod_q;
    logic                v2_q, f2_q, l2_q;

    assign a_ext  = P'(a_q);
    assign b_ext  = P'(b_q);
    assign prod_d = a_ext * b_ext;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_q <= '0;
            v2_q   <= 1'b0;
            f2_q   <= 1'b0;
            l2_q   <= 1'b0;
        end else if (ce) begin
            prod_q <= prod_d;
            v2_q   <= v1_q;
            f2_q   <= f1_q;
            l2_q   <= l1_q;
        end
    end

    logic signed [VW-1:0] val_s;
    logic                 vld_s;

    generate
        if (ACC_EN != 0) begin : g_acc
            logic signed [ACC_W-1:0] prod_ext, acc_d, acc_q;
            logic                    va_q;

            assign prod_ext = ACC_W'(prod_q);
            assign acc_d    = f2_q ? prod_ext : acc_q + prod_ext;

            // Only the closing sample of a sum is released downstream.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    acc_q <= '0;
                    va_q  <= 1'b0;
                end else if (ce) begin
                    if (v2_q) acc_q <= acc_d;
                    va_q <= v2_q & l2_q;
                end
            end

            assign val_s = acc_q;
            assign vld_s = va_q;
        end else begin : g_noacc
            logic unused_markers;
            assign unused_markers = f2_q ^ l2_q;
            assign val_s = prod_q;
            assign vld_s = v2_q;
        end
    endgenerate

    logic signed [VW-1:0] val_f;
    logic                 vld_f;

    generate
        if (ND > 0) begin : g_dly
            logic signed [VW-1:0] dval_q [ND];
            logic                 dvld_q [ND];

            // NOTE: the delay line is reset along with the valids so a mid-stream reset leaves no stale data.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < ND; i++) begin
                        dval_q[i] <= '0;
                        dvld_q[i] <= 1'b0;
                    end
                end else if (ce) begin
                    dval_q[0] <= val_s;
                    dvld_q[0] <= vld_s;
                    for (int i = 1; i < ND; i++) begin
                        dval_q[i] <= dval_q[i-1];
                        dvld_q[i] <= dvld_q[i-1];
                    end
                end
            end

            assign val_f = dval_q[ND-1];
            assign vld_f = dvld_q[ND-1];
        end else begin : g_nodly
            assign val_f = val_s;
            assign vld_f = vld_s;
        end
    endgenerate

    logic signed [DOUT_WIDTH-1:0] rs_dout;
    logic                         rs_ovf;

    krnl_idct_round_sat #(
        .IN_WIDTH  (VW),
        .SHIFT     (SHIFT),
        .ROUND     (ROUND),
        .SAT       (SAT),
        .DOUT_WIDTH(DOUT_WIDTH)
    ) u_round_sat (
        .val_i (val_f),
        .dout_o(rs_dout),
        .ovf_o (rs_ovf)
    );

    // Final stage: result registers only load on a valid sample.
    logic                         out_valid_q, ovf_q;
    logic signed [DOUT_WIDTH-1:0] dout_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            ovf_q       <= 1'b0;
        end else if (ce) begin
            out_valid_q <= vld_f;
            if (vld_f) begin
                dout_q <= rs_dout;
                ovf_q  <= rs_ovf;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_krnl_idct_mul_pipe.sv
// Directed bench: several parameterisations driven from shared stimulus,
// each comparison checked with an immediate assertion.
module tb_krnl_idct_mul_pipe;
    import krnl_idct_mul_pkg::*;

    logic clk = 1'b0, reset_n = 1'b0, ce = 1'b1;
    logic in_valid = 1'b0, acc_first = 1'b0, acc_last = 1'b0;
    logic signed [15:0] din0 = '0, din1 = '0;
    logic signed [11:0] w0 = '0;
    logic signed [17:0] w1 = '0;

    logic        ov [5];
    logic [15:0] od [5];
    logic        oo [5];
    logic        wv [2];
    logic [23:0] wd [2];
    logic        wo [2];

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // u0 default wrap, u1 saturate, u2/u3 shift-by-2 round/trunc, u4 accumulate
    krnl_idct_mul_pipe #(.SAT(0)) u0 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .acc_first(acc_first), .acc_last(acc_last), .out_valid(ov[0]), .dout(od[0]), .ovf(oo[0]));
    krnl_idct_mul_pipe #(.SAT(1)) u1 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .acc_first(acc_first), .acc_last(acc_last), .out_valid(ov[1]), .dout(od[1]), .ovf(oo[1]));
    krnl_idct_mul_pipe #(.SHIFT(2), .ROUND(ROUND_HALF_UP), .SAT(1)) u2 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .acc_first(acc_first), .acc_last(acc_last), .out_valid(ov[2]), .dout(od[2]), .ovf(oo[2]));
    krnl_idct_mul_pipe #(.SHIFT(2), .ROUND(ROUND_TRUNC), .SAT(1)) u3 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .acc_first(acc_first), .acc_last(acc_last), .out_valid(ov[3]), .dout(od[3]), .ovf(oo[3]));
    krnl_idct_mul_pipe #(.ACC_EN(1), .SAT(1)) u4 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .acc_first(acc_first), .acc_last(acc_last), .out_valid(ov[4]), .dout(od[4]), .ovf(oo[4]));
    krnl_idct_mul_pipe #(.DIN0_WIDTH(12), .DIN1_WIDTH(18), .DOUT_WIDTH(24), .NUM_STAGE(3)) u5 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .din0(w0), .din1(w1),
        .acc_first(acc_first), .acc_last(acc_last), .out_valid(wv[0]), .dout(wd[0]), .ovf(wo[0]));
    krnl_idct_mul_pipe #(.DIN0_WIDTH(12), .DIN1_WIDTH(18), .DOUT_WIDTH(24), .NUM_STAGE(8)) u6 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .din0(w0), .din1(w1),
        .acc_first(acc_first), .acc_last(acc_last), .out_valid(wv[1]), .dout(wd[1]), .ovf(wo[1]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] s16(input int v);
        return v[15:0];
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int a, input int b, input logic f, input logic l);
        in_valid  = v;
        din0      = a[15:0];
        din1      = b[15:0];
        acc_first = f;
        acc_last  = l;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [23:0] ed [20];
    logic        eo [20];

    initial begin
        int     k;
        int     idx;
        longint p;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst_valid_u0", ov[0], 0);
        check("rst_dout_u0", od[0], 0);
        check("rst_ovf_u0", oo[0], 0);
        check("rst_valid_u4", ov[4], 0);
        check("rst_dout_u4", od[4], 0);
        reset_n = 1'b1;

        // 300*200 = 60000: wraps to 0xEA60 or clamps to 32767; >>2 gives 15000
        drive(1, 300, 200, 0, 0);
        for (int t = 0; t < 5; t++) begin
            cycle();
            drive(0, 0, 0, 0, 0);
            check("lat4_valid", ov[0], (t == 3));
            if (t == 3) begin
                check("wrap_dout", od[0], 16'hEA60);
                check("wrap_ovf", oo[0], 1);
                check("sat_dout", od[1], s16(32767));
                check("sat_ovf", oo[1], 1);
                check("shr_rnd_dout", od[2], s16(15000));
                check("shr_rnd_ovf", oo[2], 0);
                check("shr_trn_dout", od[3], s16(15000));
            end
        end

        // -7*3 = -21: round -> -5, trunc -> -6; then (-2^15)^2 clamps
        drive(1, -7, 3, 0, 0);
        for (int t = 0; t < 6; t++) begin
            cycle();
            if (t == 0) drive(1, -32768, -32768, 0, 0);
            else        drive(0, 0, 0, 0, 0);
            if (t == 3) begin
                check("neg_rnd_dout", od[2], s16(-5));
                check("neg_rnd_ovf", oo[2], 0);
                check("neg_trn_dout", od[3], s16(-6));
                check("neg_plain_dout", od[0], s16(-21));
                check("neg_plain_ovf", oo[0], 0);
            end
            if (t == 4) begin
                check("minmin_rnd_dout", od[2], s16(32767));
                check("minmin_rnd_ovf", oo[2], 1);
                check("minmin_trn_dout", od[3], s16(32767));
                check("minmin_wrap_dout", od[0], 16'h0000);
                check("minmin_wrap_ovf", oo[0], 1);
                check("minmin_sat_dout", od[1], s16(32767));
            end
            if (t == 5) check("minmin_single", ov[2], 0);
        end

        // Back-to-back 1..20 * 2
        for (int t = 0; t < 24; t++) begin
            if (t < 20) drive(1, t + 1, 2, 0, 0);
            else        drive(0, 0, 0, 0, 0);
            cycle();
            check("b2b_valid", ov[0], (t >= 3 && t < 23));
            if (t >= 3 && t < 23) check("b2b_dout", od[0], s16(2 * (t - 2)));
        end

        // Same stream with ce low for 3 cycles mid-stream
        k   = 0;
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            ce = !(c >= 10 && c < 13);
            if (ce) begin
                if (idx < 20) begin
                    drive(1, idx + 1, 2, 0, 0);
                    idx++;
                end else begin
                    drive(0, 0, 0, 0, 0);
                end
            end
            cycle();
            if (!ce) begin
                check("stall_hold_valid", ov[0], 1);
                check("stall_hold_dout", od[0], s16(2 * k));
            end else if (ov[0]) begin
                check("stall_stream_dout", od[0], s16(2 * (k + 1)));
                k++;
            end
        end
        ce = 1'b1;
        check("stall_count", k, 20);

        // Accumulate 4 x 1000*10 = 40000 -> clamps
        for (int t = 0; t < 10; t++) begin
            if (t < 4) drive(1, 1000, 10, (t == 0), (t == 3));
            else       drive(0, 0, 0, 0, 0);
            cycle();
            check("acc_sat_valid", ov[4], (t == 7));
            if (t == 7) begin
                check("acc_sat_dout", od[4], s16(32767));
                check("acc_sat_ovf", oo[4], 1);
            end
        end

        // 4 x 100*10 = 4000 with bubbles carrying junk data and markers
        for (int t = 0; t < 12; t++) begin
            case (t)
                0:       drive(1, 100, 10, 1, 0);
                1:       drive(0, 999, 999, 1, 1);
                2, 4:    drive(1, 100, 10, 0, 0);
                3:       drive(0, 999, 999, 0, 1);
                5:       drive(1, 100, 10, 0, 1);
                default: drive(0, 0, 0, 0, 0);
            endcase
            cycle();
            check("acc_bub_valid", ov[4], (t == 9));
            if (t == 9) begin
                check("acc_bub_dout", od[4], s16(4000));
                check("acc_bub_ovf", oo[4], 0);
            end
        end

        // Mid-stream asynchronous reset with samples in flight and a partial sum
        for (int t = 0; t < 4; t++) begin
            drive(1, 300, 200, (t == 0), 0);
            cycle();
        end
        drive(0, 0, 0, 0, 0);
        check("pre_rst_valid", ov[0], 1);
        check("pre_rst_ovf", oo[0], 1);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", ov[0], 0);
        check("async_rst_dout", od[0], 0);
        check("async_rst_ovf", oo[0], 0);
        check("async_rst_dout_u4", od[4], 0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        drive(1, 7, 9, 0, 1);
        for (int t = 0; t < 6; t++) begin
            cycle();
            drive(0, 0, 0, 0, 0);
            check("post_rst_flush_u0", ov[0], (t == 3));
            check("post_rst_valid_u4", ov[4], (t == 4));
            if (t == 4) begin
                check("post_rst_acc_dout", od[4], s16(63));
                check("post_rst_acc_ovf", oo[4], 0);
            end
        end

        // Drain the deep pipe before the 12x18 latency sweep
        repeat (10) cycle();

        for (int t = 0; t < 28; t++) begin
            if (t < 20) begin
                case (t)
                    0:       begin w0 = -12'sd2048; w1 = -18'sd131072; end
                    1:       begin w0 = 12'sd2047;  w1 = 18'sd131071;  end
                    default: begin w0 = 12'($urandom); w1 = 18'($urandom); end
                endcase
                p     = longint'(w0) * longint'(w1);
                ed[t] = 24'(p);
                eo[t] = (p > smax(24)) || (p < smin(24));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            cycle();
            if (t >= 2 && t < 22) begin
                check("ns3_valid", wv[0], 1);
                check("ns3_dout", wd[0], ed[t-2]);
                check("ns3_ovf", wo[0], eo[t-2]);
            end else begin
                check("ns3_idle", wv[0], 0);
            end
            if (t >= 7 && t < 27) begin
                check("ns8_valid", wv[1], 1);
                check("ns8_dout", wd[1], ed[t-7]);
                check("ns8_ovf", wo[1], eo[t-7]);
            end else begin
                check("ns8_idle", wv[1], 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
